ll_free_ptr_server: RTL and testbench

LL_FREE_PTR_SERVER -- requirements
Module: ll_free_ptr_server

---
 rtl/ll_pkg.sv | 13 +
 rtl/ll_ptr_fifo.sv | 55 +++++
 rtl/ll_free_ptr_server.sv | 130 +++++++++++++
 tb/tb_ll_free_ptr_server.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared definitions for the linked-list free-pointer server.
// Default pointer geometry and the server FSM state type.
package ll_pkg;

    localparam int unsigned PTR_WD = 4;
    localparam int unsigned DEPTH  = 2**PTR_WD;

    typedef enum logic {
        INIT,
        READY
    } t_free_srv_st;

endpackage

// File: rtl/ll_ptr_fifo.sv
// Pointer storage FIFO: DEPTH x PTR_WD, one write and one read port,
// show-ahead read data and an occupancy count.
module ll_ptr_fifo #(
    parameter int unsigned PTR_WD = ll_pkg::PTR_WD,
    parameter int unsigned DEPTH  = 2**PTR_WD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [PTR_WD-1:0] wr_data,
    input  logic              pop,
    output logic [PTR_WD-1:0] rd_data,
    output logic [PTR_WD:0]   count
);

    logic [PTR_WD-1:0] mem [DEPTH];
    logic [PTR_WD-1:0] wr_idx;
    logic [PTR_WD-1:0] rd_idx;

    // Explicit wrap so a DEPTH below 2**PTR_WD still wraps modulo DEPTH.
    function automatic logic [PTR_WD-1:0] next_idx(input logic [PTR_WD-1:0] idx);
        return (idx == PTR_WD'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        rd_data = mem[rd_idx];
    end

endmodule

// File: rtl/ll_free_ptr_server.sv
// Free-pointer server: fills a FIFO with every pointer after reset, then
// hands pointers out on alloc_req and takes them back on free_vld.
module ll_free_ptr_server #(
    parameter int unsigned PTR_WD = ll_pkg::PTR_WD,
    parameter int unsigned DEPTH  = 2**PTR_WD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_req,
    input  logic              free_vld,
    input  logic [PTR_WD-1:0] free_ptr,
    output logic [PTR_WD-1:0] nxt_ptr_from_servr,
    output logic              nxt_ptr_vld,
    output logic              srv_ready,
    output logic [PTR_WD:0]   free_cnt,
    output logic              underflow_err,
    output logic              overflow_err,
    output logic              dbl_free_err
);
    import ll_pkg::*;

    localparam int unsigned CNT_WD = PTR_WD + 1;

    t_free_srv_st      state;
    t_free_srv_st      state_nxt;
    logic [CNT_WD-1:0] init_cnt;
    logic [DEPTH-1:0]  bitmap;
    logic [PTR_WD-1:0] head_ptr;
    logic [PTR_WD-1:0] fifo_wr_data;
    logic              fifo_push;
    logic              fifo_pop;
    logic              empty;
    logic              full;
    logic              free_in_range;
    logic              under_hit;
    logic              over_hit;
    logic              dbl_hit;

    ll_ptr_fifo #(
        .PTR_WD (PTR_WD),
        .DEPTH  (DEPTH)
    ) u_ptr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (head_ptr),
        .count   (free_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT && init_cnt != CNT_WD'(DEPTH)) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // init_cnt reaching DEPTH means the last pointer went in on the previous edge.
    always_comb begin
        state_nxt     = state;
        srv_ready     = 1'b0;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_wr_data  = '0;
        under_hit     = 1'b0;
        over_hit      = 1'b0;
        dbl_hit       = 1'b0;
        empty         = (free_cnt == '0);
        full          = (free_cnt == CNT_WD'(DEPTH));
        free_in_range = ({1'b0, free_ptr} < CNT_WD'(DEPTH));
        case (state)
            INIT: begin
                if (init_cnt == CNT_WD'(DEPTH)) begin
                    state_nxt = READY;
                end else begin
                    fifo_push    = 1'b1;
                    fifo_wr_data = init_cnt[PTR_WD-1:0];
                end
            end
            READY: begin
                srv_ready    = 1'b1;
                under_hit    = alloc_req && empty;
                fifo_pop     = alloc_req && !empty;
                over_hit     = free_vld && full;
                dbl_hit      = free_vld && !full && (!free_in_range || !bitmap[free_ptr]);
                fifo_push    = free_vld && !full && !dbl_hit;
                fifo_wr_data = free_ptr;
            end
            default: state_nxt = INIT;
        endcase
    end

    // A bit is cleared whenever its pointer enters the FIFO (fill or free).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bitmap <= '1;
        end else begin
            if (fifo_push) begin
                bitmap[fifo_wr_data] <= 1'b0;
            end
            if (fifo_pop) begin
                bitmap[head_ptr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            underflow_err <= 1'b0;
            overflow_err  <= 1'b0;
            dbl_free_err  <= 1'b0;
        end else begin
            if (under_hit) underflow_err <= 1'b1;
            if (over_hit)  overflow_err  <= 1'b1;
            if (dbl_hit)   dbl_free_err  <= 1'b1;
        end
    end

    always_comb begin
        nxt_ptr_vld        = srv_ready && !empty;
        nxt_ptr_from_servr = nxt_ptr_vld ? head_ptr : '0;
    end

endmodule

// File: tb/tb_ll_free_ptr_server.sv
// Directed bench for ll_free_ptr_server with PTR_WD=3, DEPTH=8.
module tb_ll_free_ptr_server;

    logic       clk;
    logic       reset_n;
    logic       alloc_req;
    logic       free_vld;
    logic [2:0] free_ptr;
    logic [2:0] nxt_ptr_from_servr;
    logic       nxt_ptr_vld;
    logic       srv_ready;
    logic [3:0] free_cnt;
    logic       underflow_err;
    logic       overflow_err;
    logic       dbl_free_err;

    int n_checks = 0;
    int n_fail   = 0;

    ll_free_ptr_server #(
        .PTR_WD (3),
        .DEPTH  (8)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .alloc_req          (alloc_req),
        .free_vld           (free_vld),
        .free_ptr           (free_ptr),
        .nxt_ptr_from_servr (nxt_ptr_from_servr),
        .nxt_ptr_vld        (nxt_ptr_vld),
        .srv_ready          (srv_ready),
        .free_cnt           (free_cnt),
        .underflow_err      (underflow_err),
        .overflow_err       (overflow_err),
        .dbl_free_err       (dbl_free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset edge then release; checks the state right after the reset edge.
    task automatic test_reset();
        reset_n = 1'b0; alloc_req = 1'b0; free_vld = 1'b0; free_ptr = '0;
        tick();
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_free_cnt: got %0d exp 0", free_cnt); end
        n_checks++; if (srv_ready !== 1'b0) begin n_fail++; $display("FAIL rst_srv_ready: got %0b exp 0", srv_ready); end
        n_checks++; if (nxt_ptr_vld !== 1'b0) begin n_fail++; $display("FAIL rst_nxt_vld: got %0b exp 0", nxt_ptr_vld); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd0) begin n_fail++; $display("FAIL rst_nxt_ptr: got %0d exp 0", nxt_ptr_from_servr); end
        n_checks++; if ({underflow_err, overflow_err, dbl_free_err} !== 3'b000) begin n_fail++; $display("FAIL rst_errs: got %b exp 000", {underflow_err, overflow_err, dbl_free_err}); end
        reset_n = 1'b1;
    endtask

    task automatic init_dut();
        test_reset();
        repeat (9) tick();
        n_checks++; if (srv_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready: got %0b exp 1", srv_ready); end
    endtask

    // Requests held active during the fill must be ignored.
    task automatic test_init();
        test_reset();
        alloc_req = 1'b1; free_vld = 1'b1; free_ptr = 3'd3;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++; if (free_cnt !== 4'(i)) begin n_fail++; $display("FAIL init_fill_cnt: got %0d exp %0d", free_cnt, i); end
            n_checks++; if (srv_ready !== 1'b0) begin n_fail++; $display("FAIL init_early_ready: got %0b exp 0 at cycle %0d", srv_ready, i); end
            n_checks++; if (nxt_ptr_from_servr !== 3'd0) begin n_fail++; $display("FAIL init_nxt_ptr: got %0d exp 0", nxt_ptr_from_servr); end
        end
        alloc_req = 1'b0; free_vld = 1'b0;
        tick();
        n_checks++; if (srv_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready9: got %0b exp 1", srv_ready); end
        n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL init_cnt9: got %0d exp 8", free_cnt); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd0) begin n_fail++; $display("FAIL init_head: got %0d exp 0", nxt_ptr_from_servr); end
        n_checks++; if (nxt_ptr_vld !== 1'b1) begin n_fail++; $display("FAIL init_vld: got %0b exp 1", nxt_ptr_vld); end
        n_checks++; if ({underflow_err, overflow_err, dbl_free_err} !== 3'b000) begin n_fail++; $display("FAIL init_errs: got %b exp 000", {underflow_err, overflow_err, dbl_free_err}); end
    endtask

    task automatic test_back_to_back();
        init_dut();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (nxt_ptr_from_servr !== 3'(i)) begin n_fail++; $display("FAIL b2b_head: got %0d exp %0d", nxt_ptr_from_servr, i); end
            alloc_req = 1'b1;
            tick();
        end
        alloc_req = 1'b0;
        n_checks++; if (nxt_ptr_from_servr !== 3'd3) begin n_fail++; $display("FAIL b2b_next: got %0d exp 3", nxt_ptr_from_servr); end
        n_checks++; if (free_cnt !== 4'd5) begin n_fail++; $display("FAIL b2b_cnt: got %0d exp 5", free_cnt); end
    endtask

    // Continues from test_back_to_back: drains the list then probes empty behaviour.
    task automatic test_underflow();
        for (int i = 3; i < 8; i++) begin
            n_checks++; if (nxt_ptr_from_servr !== 3'(i)) begin n_fail++; $display("FAIL drain_head: got %0d exp %0d", nxt_ptr_from_servr, i); end
            alloc_req = 1'b1;
            tick();
        end
        alloc_req = 1'b0;
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL empty_cnt: got %0d exp 0", free_cnt); end
        n_checks++; if (nxt_ptr_vld !== 1'b0) begin n_fail++; $display("FAIL empty_vld: got %0b exp 0", nxt_ptr_vld); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd0) begin n_fail++; $display("FAIL empty_ptr: got %0d exp 0", nxt_ptr_from_servr); end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL early_underflow: got %0b exp 0", underflow_err); end
        alloc_req = 1'b1; tick(); alloc_req = 1'b0;
        n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL underflow: got %0b exp 1", underflow_err); end
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL underflow_cnt: got %0d exp 0", free_cnt); end
        free_vld = 1'b1; free_ptr = 3'd5; tick(); free_vld = 1'b0;
        n_checks++; if (nxt_ptr_from_servr !== 3'd5) begin n_fail++; $display("FAIL refill_head: got %0d exp 5", nxt_ptr_from_servr); end
        n_checks++; if (free_cnt !== 4'd1) begin n_fail++; $display("FAIL refill_cnt: got %0d exp 1", free_cnt); end
        alloc_req = 1'b1; tick();
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL realloc_cnt: got %0d exp 0", free_cnt); end
        // Empty list: free is taken, alloc is refused, no bypass of ptr 2.
        free_vld = 1'b1; free_ptr = 3'd2; tick(); alloc_req = 1'b0; free_vld = 1'b0;
        n_checks++; if (free_cnt !== 4'd1) begin n_fail++; $display("FAIL nobypass_cnt: got %0d exp 1", free_cnt); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd2) begin n_fail++; $display("FAIL nobypass_head: got %0d exp 2", nxt_ptr_from_servr); end
        n_checks++; if ({overflow_err, dbl_free_err} !== 2'b00) begin n_fail++; $display("FAIL nobypass_errs: got %b exp 00", {overflow_err, dbl_free_err}); end
    endtask

    task automatic test_overflow_dbl();
        init_dut();
        free_vld = 1'b1; free_ptr = 3'd2; tick(); free_vld = 1'b0;
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow: got %0b exp 1", overflow_err); end
        n_checks++; if (dbl_free_err !== 1'b0) begin n_fail++; $display("FAIL overflow_prio: got %0b exp 0", dbl_free_err); end
        n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL overflow_cnt: got %0d exp 8", free_cnt); end
        alloc_req = 1'b1; tick(); alloc_req = 1'b0;
        n_checks++; if (nxt_ptr_from_servr !== 3'd1) begin n_fail++; $display("FAIL ovd_head: got %0d exp 1", nxt_ptr_from_servr); end
        free_vld = 1'b1; free_ptr = 3'd0; tick();
        n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL legal_free_cnt: got %0d exp 8", free_cnt); end
        n_checks++; if (dbl_free_err !== 1'b0) begin n_fail++; $display("FAIL legal_free_dbl: got %0b exp 0", dbl_free_err); end
        tick(); free_vld = 1'b0;
        n_checks++; if (dbl_free_err !== 1'b0) begin n_fail++; $display("FAIL full_refree_dbl: got %0b exp 0", dbl_free_err); end
        n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL full_refree_cnt: got %0d exp 8", free_cnt); end
        alloc_req = 1'b1; tick(); alloc_req = 1'b0;
        free_vld = 1'b1; free_ptr = 3'd0; tick(); free_vld = 1'b0;
        n_checks++; if (dbl_free_err !== 1'b1) begin n_fail++; $display("FAIL dbl_free: got %0b exp 1", dbl_free_err); end
        n_checks++; if (free_cnt !== 4'd7) begin n_fail++; $display("FAIL dbl_free_cnt: got %0d exp 7", free_cnt); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd2) begin n_fail++; $display("FAIL dbl_free_head: got %0d exp 2", nxt_ptr_from_servr); end
    endtask

    task automatic test_simultaneous();
        logic [2:0] q[$];
        logic [2:0] a[$];
        logic [2:0] fp;
        logic       do_a;
        logic       do_f;
        int         idx;
        init_dut();
        alloc_req = 1'b1; repeat (4) tick(); alloc_req = 1'b0;
        n_checks++; if (free_cnt !== 4'd4) begin n_fail++; $display("FAIL sim_pre_cnt: got %0d exp 4", free_cnt); end
        alloc_req = 1'b1; free_vld = 1'b1; free_ptr = 3'd1; tick();
        n_checks++; if (free_cnt !== 4'd4) begin n_fail++; $display("FAIL sim_cnt: got %0d exp 4", free_cnt); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd5) begin n_fail++; $display("FAIL sim_head: got %0d exp 5", nxt_ptr_from_servr); end
        // Freeing the pointer being handed out this same cycle is a double free.
        free_ptr = 3'd5; tick(); alloc_req = 1'b0; free_vld = 1'b0;
        n_checks++; if (dbl_free_err !== 1'b1) begin n_fail++; $display("FAIL sim_self_free: got %0b exp 1", dbl_free_err); end
        n_checks++; if (free_cnt !== 4'd3) begin n_fail++; $display("FAIL sim_self_cnt: got %0d exp 3", free_cnt); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd6) begin n_fail++; $display("FAIL sim_self_head: got %0d exp 6", nxt_ptr_from_servr); end
        q = '{3'd6, 3'd7, 3'd1};
        a = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int c = 0; c < 20; c++) begin
            do_a = (q.size() > 0) && ($urandom_range(1, 0) == 1);
            do_f = (a.size() > 0) && ($urandom_range(1, 0) == 1);
            fp = '0;
            if (do_f) begin
                idx = $urandom_range(a.size() - 1, 0);
                fp = a[idx];
                a.delete(idx);
            end
            if (q.size() > 0) begin
                n_checks++; if (nxt_ptr_from_servr !== q[0]) begin n_fail++; $display("FAIL rnd_head: got %0d exp %0d cycle %0d", nxt_ptr_from_servr, q[0], c); end
            end
            alloc_req = do_a; free_vld = do_f; free_ptr = fp;
            tick();
            if (do_a) a.push_back(q.pop_front());
            if (do_f) q.push_back(fp);
            n_checks++; if (free_cnt !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_cnt: got %0d exp %0d cycle %0d", free_cnt, q.size(), c); end
        end
        alloc_req = 1'b0; free_vld = 1'b0;
        n_checks++; if ({underflow_err, overflow_err} !== 2'b00) begin n_fail++; $display("FAIL rnd_errs: got %b exp 00", {underflow_err, overflow_err}); end
    endtask

    task automatic test_reset_mid_init();
        test_reset();
        repeat (3) tick();
        n_checks++; if (free_cnt !== 4'd3) begin n_fail++; $display("FAIL mid_partial_cnt: got %0d exp 3", free_cnt); end
        reset_n = 1'b0; tick();
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d exp 0", free_cnt); end
        reset_n = 1'b1;
        repeat (8) tick();
        n_checks++; if (srv_ready !== 1'b0) begin n_fail++; $display("FAIL mid_early_ready: got %0b exp 0", srv_ready); end
        tick();
        n_checks++; if (srv_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b exp 1", srv_ready); end
        n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL mid_cnt: got %0d exp 8", free_cnt); end
        n_checks++; if (nxt_ptr_from_servr !== 3'd0) begin n_fail++; $display("FAIL mid_head: got %0d exp 0", nxt_ptr_from_servr); end
        n_checks++; if ({underflow_err, overflow_err, dbl_free_err} !== 3'b000) begin n_fail++; $display("FAIL mid_errs: got %b exp 000", {underflow_err, overflow_err, dbl_free_err}); end
    endtask

    initial begin
        reset_n = 1'b0; alloc_req = 1'b0; free_vld = 1'b0; free_ptr = '0;
        test_reset();
        test_init();
        test_back_to_back();
        test_underflow();
        test_overflow_dbl();
        test_simultaneous();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
